sram_axi_slave: RTL

SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

---
 rtl/sram_axi_slave_if.sv | 55 +++++
 rtl/sram_axi_slave.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sram_axi_slave_if.sv
// AXI3-style slave bus bundle for sram_axi_slave: AW, W, B, AR and R channels.
// The master modport is the bus initiator; the slave modport is the SRAM bridge.
interface sram_axi_slave_if #(
  parameter int IDW = 8
) ();
  logic [IDW-1:0] AWID;
  logic [31:0]    AWADDR;
  logic [3:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;

  logic [31:0]    WDATA;
  logic [3:0]     WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;

  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;

  logic [IDW-1:0] ARID;
  logic [31:0]    ARADDR;
  logic [3:0]     ARLEN;
  logic [2:0]     ARSIZE;
  logic [1:0]     ARBURST;
  logic           ARVALID;
  logic           ARREADY;

  logic [IDW-1:0] RID;
  logic [31:0]    RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/sram_axi_slave.sv
// Single-outstanding AXI slave bridging bursts onto a 1-cycle-latency synchronous SRAM.
// State table: IDLE accept AW/AR | READ stream beats | WRITE accept W beats | RESP drive B.
module sram_axi_slave #(
  parameter int IDW = 8,
  parameter int AW  = 14
) (
  input  logic                clk,
  input  logic                rst,
  sram_axi_slave_if.slave     axi,
  output logic                CEB,
  output logic                WEB,
  output logic [3:0]          BWEB,
  output logic [AW-1:0]       A,
  output logic [31:0]         DI,
  input  logic [31:0]         DO
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [3:0]     len_q, len_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [1:0]     burst_q, burst_d;
  logic           rvalid_q, rvalid_d;

  logic [AW-1:0]  addr_nxt;
  logic           rlast;
  logic           r_hs;
  logic           unused_inputs;

  assign unused_inputs = ^{axi.AWLEN, axi.AWSIZE, axi.ARSIZE,
                           axi.AWADDR[31:AW+2], axi.AWADDR[1:0],
                           axi.ARADDR[31:AW+2], axi.ARADDR[1:0]};

  // FIXED holds the word address; INCR (and anything else) steps it, wrapping at 2^AW.
  assign addr_nxt = (burst_q == 2'b00) ? addr_q : addr_q + AW'(1);
  assign rlast    = rvalid_q && (cnt_q == len_q);
  assign r_hs     = rvalid_q && axi.RREADY;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    rvalid_d    = rvalid_q;

    axi.AWREADY = 1'b0;
    axi.ARREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BID     = id_q;
    axi.BRESP   = 2'b00;
    axi.RID     = id_q;
    axi.RRESP   = 2'b00;
    axi.RDATA   = DO;
    axi.RVALID  = rvalid_q;
    axi.RLAST   = rlast;
    CEB         = 1'b1;
    WEB         = 1'b1;
    BWEB        = 4'hF;
    A           = addr_q;
    DI          = 32'h0;

    case (state_q)
      IDLE: begin
        axi.AWREADY = axi.AWVALID;
        axi.ARREADY = axi.ARVALID & ~axi.AWVALID;
        rvalid_d    = 1'b0;
        if (axi.AWVALID) begin
          id_d    = axi.AWID;
          addr_d  = axi.AWADDR[AW+1:2];
          burst_d = axi.AWBURST;
          state_d = WRITE;
        end else if (axi.ARVALID) begin
          id_d    = axi.ARID;
          addr_d  = axi.ARADDR[AW+1:2];
          len_d   = axi.ARLEN;
          burst_d = axi.ARBURST;
          cnt_d   = 4'd0;
          state_d = READ;
        end
      end
      READ: begin
        // The SRAM is read every cycle; a stall re-reads the same word so RDATA holds.
        CEB      = 1'b0;
        rvalid_d = 1'b1;
        if (r_hs) begin
          A      = addr_nxt;
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 4'd1;
          if (rlast) begin
            CEB      = 1'b1;
            rvalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      WRITE: begin
        axi.WREADY = 1'b1;
        if (axi.WVALID) begin
          CEB    = 1'b0;
          WEB    = 1'b0;
          BWEB   = axi.WSTRB;
          DI     = axi.WDATA;
          addr_d = addr_nxt;
          if (axi.WLAST) state_d = RESP;
        end
      end
      RESP: begin
        axi.BVALID = 1'b1;
        if (axi.BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule
